// File: rtl/countdown9999_if.sv
// countdown9999_if: control/preset/display bundle for the four-digit BCD
// down-counter.
//   master side (driver): load, start, stop, d0..d3
//   slave side (counter): s0..s3, z0..z3, busy, zero, done, state (debug)
// Handshake: there is no valid/ready pair; control inputs are level-sampled
// on every falling clock edge, and every output is valid at all times
// (registered, or combinational from registers).
interface countdown9999_if;
  logic       load;
  logic       start;
  logic       stop;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] s0, s1, s2, s3;
  logic [6:0] z0, z1, z2, z3;
  logic       busy;
  logic       zero;
  logic       done;
  logic [1:0] state;

  modport master (
    output load, start, stop, d0, d1, d2, d3,
    input  s0, s1, s2, s3, z0, z1, z2, z3, busy, zero, done, state
  );

  modport slave (
    input  load, start, stop, d0, d1, d2, d3,
    output s0, s1, s2, s3, z0, z1, z2, z3, busy, zero, done, state
  );
endinterface

// File: rtl/countdown9999.sv
// print_7: BCD digit to 7-segment code, active-high, bit order {g,f,e,d,c,b,a}.
//   bcd_i : BCD digit (values above 9 blank the display)
//   seg_o : segment code
module print_7 (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'h00;
    case (bcd_i)
      4'd0: seg_o = 7'h3F;
      4'd1: seg_o = 7'h06;
      4'd2: seg_o = 7'h5B;
      4'd3: seg_o = 7'h4F;
      4'd4: seg_o = 7'h66;
      4'd5: seg_o = 7'h6D;
      4'd6: seg_o = 7'h7D;
      4'd7: seg_o = 7'h07;
      4'd8: seg_o = 7'h7F;
      4'd9: seg_o = 7'h6F;
      default: seg_o = 7'h00;
    endcase
  end
endmodule

// countdown9999: four-digit BCD down-counter with preset load, start/stop
// and expiry detection. All state changes on the falling edge of clk.
//   clk  : clock (falling edge active)
//   rst  : asynchronous active-high reset
//   bus  : countdown9999_if.slave (controls, presets, digits, segments,
//          busy/zero/done, debug state)
// WRAP = 0 stops at 0000 and expires; WRAP = 1 wraps 0000 -> 9999.
module countdown9999 #(
  parameter bit WRAP = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  countdown9999_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] dig_q [4];
  logic [3:0] dig_d [4];
  logic [3:0] dec   [4];
  logic [3:0] pre   [4];
  logic       done_q, done_d;
  logic       borrow;
  logic       is_zero;
  logic       dec_zero;

  function automatic logic [3:0] clamp9(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  always_comb begin
    pre[0] = clamp9(bus.d0);
    pre[1] = clamp9(bus.d1);
    pre[2] = clamp9(bus.d2);
    pre[3] = clamp9(bus.d3);
  end

  // BCD decrement: a zero digit becomes 9 and passes the borrow upward.
  // 0000 naturally produces 9999, which only RUN with WRAP=1 can reach.
  always_comb begin
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dec[i] = dig_q[i];
      if (borrow) begin
        if (dig_q[i] == 4'd0) begin
          dec[i] = 4'd9;
        end else begin
          dec[i] = dig_q[i] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  assign is_zero  = (dig_q[0] == 4'd0) && (dig_q[1] == 4'd0) &&
                    (dig_q[2] == 4'd0) && (dig_q[3] == 4'd0);
  assign dec_zero = (dec[0] == 4'd0) && (dec[1] == 4'd0) &&
                    (dec[2] == 4'd0) && (dec[3] == 4'd0);

  // Next-state: load beats stop beats start.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    for (int i = 0; i < 4; i++) dig_d[i] = dig_q[i];

    if (bus.load) begin
      state_d = IDLE;
      for (int i = 0; i < 4; i++) dig_d[i] = pre[i];
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && (!is_zero || WRAP)) state_d = RUN;
        end
        RUN: begin
          if (bus.stop) begin
            state_d = IDLE;
          end else begin
            for (int i = 0; i < 4; i++) dig_d[i] = dec[i];
            if (dec_zero) begin
              done_d = 1'b1;
              if (!WRAP) state_d = EXPIRED;
            end
          end
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      for (int i = 0; i < 4; i++) dig_q[i] <= 4'd0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      for (int i = 0; i < 4; i++) dig_q[i] <= dig_d[i];
    end
  end

  assign bus.s0    = dig_q[0];
  assign bus.s1    = dig_q[1];
  assign bus.s2    = dig_q[2];
  assign bus.s3    = dig_q[3];
  assign bus.busy  = (state_q == RUN);
  assign bus.zero  = is_zero;
  assign bus.done  = done_q;
  assign bus.state = state_q;

  print_7 u_seg0 (.bcd_i(dig_q[0]), .seg_o(bus.z0));
  print_7 u_seg1 (.bcd_i(dig_q[1]), .seg_o(bus.z1));
  print_7 u_seg2 (.bcd_i(dig_q[2]), .seg_o(bus.z2));
  print_7 u_seg3 (.bcd_i(dig_q[3]), .seg_o(bus.z3));

endmodule
